// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO, with EX-stage stall generation.
// Optional feature: define MULDIV_EARLY_OUT_EN to end multiplies once the remaining multiplier bits are zero.

module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hilo_rd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [2*WIDTH-1:0] r_acc;   // mul: product; div: {remainder, dividend shifting into quotient}
    logic [2*WIDTH-1:0] r_opa;   // mul: left-shifting multiplicand; div: divisor in low half
    logic [WIDTH-1:0]   r_opb;   // mul: right-shifting multiplier
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dz;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_div0;
    logic               w_last;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_sub;
    logic [2*WIDTH-1:0] w_div_acc;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    // op[0]==0 selects the signed variants; signed operands run as magnitudes.
    assign w_a_neg = ~op[0] & operand_a[WIDTH-1];
    assign w_b_neg = ~op[0] & operand_b[WIDTH-1];
    assign w_abs_a = w_a_neg ? -operand_a : operand_a;
    assign w_abs_b = w_b_neg ? -operand_b : operand_b;
    assign w_div0  = op[1] & (operand_b == '0);

    // Restoring divide step: the partial remainder stays below the divisor, so WIDTH bits suffice.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = w_div_shift >= {1'b0, r_opa[WIDTH-1:0]};
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_opa[WIDTH-1:0];
    assign w_div_acc   = {(w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_div_ge};
    assign w_mul_acc   = r_opb[0] ? (r_acc + r_opa) : r_acc;

`ifdef MULDIV_EARLY_OUT_EN
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) | (~r_is_div & (r_opb[WIDTH-1:1] == '0));
`else
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

    assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
    assign w_quo      = r_acc[WIDTH-1:0];
    assign w_rem      = r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod_fix[WIDTH-1:0];
        if (r_dz) begin
            w_fix_hi = w_rem;
            w_fix_lo = w_quo;
        end else if (r_is_div) begin
            w_fix_hi = r_neg_rem ? -w_rem : w_rem;
            w_fix_lo = r_neg_res ? -w_quo : w_quo;
        end
    end

    // start is taken only in IDLE; otherwise stall holds it in EX until the first IDLE cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_div0 ? S_FIX : S_RUN;
            S_RUN:   if (w_last) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc     <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_cnt     <= '0;
                    r_is_div  <= op[1];
                    r_neg_res <= w_a_neg ^ w_b_neg;
                    r_neg_rem <= w_a_neg;
                    r_dz      <= w_div0;
                    if (w_div0) begin
                        r_acc <= {operand_a, {WIDTH{1'b1}}};
                    end else if (op[1]) begin
                        r_acc <= {{WIDTH{1'b0}}, w_abs_a};
                        r_opa <= {{WIDTH{1'b0}}, w_abs_b};
                    end else begin
                        r_acc <= '0;
                        r_opa <= {{WIDTH{1'b0}}, w_abs_a};
                        r_opb <= w_abs_b;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_is_div) begin
                        r_acc <= w_div_acc;
                    end else begin
                        r_acc <= w_mul_acc;
                        r_opa <= r_opa << 1;
                        r_opb <= r_opb >> 1;
                    end
                end
                S_FIX: begin
                    r_hi   <= w_fix_hi;
                    r_lo   <= w_fix_lo;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign stall = busy & (start | hilo_rd);
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
